// File: rtl/obi_arb_pkg.sv
// Shared constants and helpers for the OBI peripheral arbiter.
package obi_arb_pkg;

    localparam int unsigned OBI_BE_W   = 4;
    localparam int unsigned DEF_ADDR_W = 24;
    localparam int unsigned DEF_DATA_W = 32;

    // Index width for n entries; never below one bit so single-entry vectors stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO holding the requester ID of each granted, not yet answered OBI transaction.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = idx_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/obi_peripheral_arbiter.sv
// Round-robin arbiter sharing one OBI peripheral port among NUM_REQ requesters,
// with responses steered back through an in-order ID FIFO.
module obi_peripheral_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           m_req,
    input  logic [NUM_REQ-1:0]           m_we,
    input  logic [OBI_BE_W*NUM_REQ-1:0]  m_be,
    input  logic [ADDR_W*NUM_REQ-1:0]    m_addr,
    input  logic [DATA_W*NUM_REQ-1:0]    m_wdata,
    output logic [NUM_REQ-1:0]           m_gnt,
    output logic [NUM_REQ-1:0]           m_rvalid,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         s_req,
    output logic                         s_we,
    output logic [OBI_BE_W-1:0]          s_be,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic                         s_gnt,
    input  logic                         s_rvalid,
    input  logic [DATA_W-1:0]            s_rdata,
    output logic                         err
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    logic             locked_q;
    logic [IDX_W-1:0] sel_q, rr_ptr_q, cand, fifo_head;
    logic             err_q;
    logic             fifo_full, fifo_empty, accept, pop;

    // First requester at or after rr_ptr, wrapping; a stalled request keeps its slot.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        cand  = rr_ptr_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = (int'(rr_ptr_q) + i) % int'(NUM_REQ);
            if (!found && m_req[idx]) begin
                found = 1'b1;
                cand  = IDX_W'(idx);
            end
        end
        if (locked_q) cand = sel_q;
    end

    assign s_req   = m_req[cand] & ~fifo_full;
    assign s_we    = m_we[cand];
    assign s_be    = m_be[cand*OBI_BE_W +: OBI_BE_W];
    assign s_addr  = m_addr[cand*ADDR_W +: ADDR_W];
    assign s_wdata = m_wdata[cand*DATA_W +: DATA_W];
    assign m_rdata = s_rdata;
    assign accept  = s_req & s_gnt;
    assign pop     = s_rvalid & ~fifo_empty;
    assign err     = err_q;

    always_comb begin
        m_gnt           = '0;
        m_gnt[cand]     = accept;
        m_rvalid        = '0;
        m_rvalid[fifo_head] = pop;
    end

    // Lock holds exactly while a presented request waits for grant; a retracted
    // request or an accept releases it on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= 1'b0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            locked_q <= s_req & ~s_gnt;
            if (s_req && !s_gnt) sel_q <= cand;
            if (accept) rr_ptr_q <= (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (s_rvalid && fifo_empty) err_q <= 1'b1;
        end
    end

    obi_arb_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (cand),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_obi_peripheral_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based reference of the arbiter.
module tb_obi_peripheral_arbiter;

    localparam int NR = 4;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int MO = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   m_req, m_we, m_gnt, m_rvalid;
    logic [4*NR-1:0] m_be;
    logic [AW*NR-1:0] m_addr;
    logic [DW*NR-1:0] m_wdata;
    logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
    logic            s_req, s_we, s_gnt, s_rvalid, err;
    logic [3:0]      s_be;
    logic [AW-1:0]   s_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    obi_peripheral_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_OUT (MO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_be     (s_be),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_gnt    (s_gnt),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata),
        .err      (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [3:0] be,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m_req[i]            = 1'b1;
        m_we[i]             = we;
        m_be[i*4 +: 4]      = be;
        m_addr[i*AW +: AW]  = addr;
        m_wdata[i*DW +: DW] = wdata;
    endtask

    task automatic all_req();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 4'hF, AW'(32'h1000 * (i + 1)), DW'(i));
    endtask

    // Reference state: round-robin start, id of a stalled requester (-1 if none),
    // and the ordered list of outstanding requester ids.
    int rr, lock;
    int q[$];

    initial begin
        int exp_cand, cand_found;
        logic exp_sreq;
        logic [NR-1:0] exp_gnt, exp_rv;

        clear_inputs();
        rst = 1'b1;
        do_reset();

        // Reset state
        mid();
        check("reset_s_req", 64'(s_req), 0);
        check("reset_m_gnt", 64'(m_gnt), 0);
        check("reset_m_rvalid", 64'(m_rvalid), 0);
        check("reset_err", 64'(err), 0);

        // Single requester
        step();
        set_req(1, 1'b1, 4'hF, 24'h000100, 32'hDEADBEEF);
        s_gnt = 1'b1;
        mid();
        check("single_gnt", 64'(m_gnt), 64'b0010);
        check("single_addr", 64'(s_addr), 64'h100);
        check("single_wdata", 64'(s_wdata), 64'hDEADBEEF);
        check("single_we_be", {59'd0, s_we, s_be}, {59'd0, 1'b1, 4'hF});
        step();
        clear_inputs();
        step();
        s_rvalid = 1'b1; s_rdata = 32'h12345678;
        mid();
        check("single_rvalid", 64'(m_rvalid), 64'b0010);
        check("single_rdata", 64'(m_rdata), 64'h12345678);
        step();

        // Round-robin with all requesters busy
        do_reset();
        all_req();
        s_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_rvalid = (k > 0);
            mid();
            check("rr_gnt", 64'(m_gnt), 64'(1 << (k % 4)));
            check("rr_rvalid", 64'(m_rvalid), (k > 0) ? 64'(1 << ((k - 1) % 4)) : 64'd0);
            step();
        end

        // Stall lock: requester 2 holds the port until granted
        do_reset();
        set_req(2, 1'b0, 4'h3, 24'h00AA00, 32'h2);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) set_req(0, 1'b1, 4'hF, 24'h000F00, 32'h0);
            mid();
            check("stall_addr", 64'(s_addr), 64'h00AA00);
            check("stall_no_gnt", 64'(m_gnt), 0);
            step();
        end
        s_gnt = 1'b1;
        mid();
        check("stall_gnt2", 64'(m_gnt), 64'b0100);
        step();
        m_req[2] = 1'b0;
        mid();
        check("stall_gnt0", 64'(m_gnt), 64'b0001);
        step();
        clear_inputs();
        s_rvalid = 1'b1;
        mid();
        check("stall_rsp2", 64'(m_rvalid), 64'b0100);
        step();
        mid();
        check("stall_rsp0", 64'(m_rvalid), 64'b0001);
        step();

        // Outstanding limit
        do_reset();
        s_gnt = 1'b1;
        set_req(0, 1'b0, 4'hF, 24'h10, 32'h0);
        step();
        m_req = '0;
        set_req(1, 1'b0, 4'hF, 24'h20, 32'h0);
        step();
        m_req = '0;
        set_req(2, 1'b0, 4'hF, 24'h30, 32'h0);
        for (int k = 0; k < 2; k++) begin
            mid();
            check("full_s_req", 64'(s_req), 0);
            check("full_gnt", 64'(m_gnt), 0);
            step();
        end
        s_rvalid = 1'b1;
        mid();
        check("full_rsp0", 64'(m_rvalid), 64'b0001);
        check("full_pop_no_gnt", 64'(m_gnt), 0);
        step();
        s_rvalid = 1'b0;
        mid();
        check("full_gnt2", 64'(m_gnt), 64'b0100);
        step();
        m_req = '0;
        s_rvalid = 1'b1;
        mid();
        check("full_rsp1", 64'(m_rvalid), 64'b0010);
        step();
        mid();
        check("full_rsp2", 64'(m_rvalid), 64'b0100);
        step();

        // Spurious response
        clear_inputs();
        s_rvalid = 1'b1;
        mid();
        check("spur_rvalid", 64'(m_rvalid), 0);
        step();
        s_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            check("spur_err", 64'(err), 1);
            step();
        end
        do_reset();
        mid();
        check("spur_err_cleared", 64'(err), 0);

        // Mid-transaction reset
        step();
        s_gnt = 1'b1;
        set_req(0, 1'b0, 4'hF, 24'h10, 32'h0);
        set_req(1, 1'b0, 4'hF, 24'h20, 32'h0);
        step();
        step();
        do_reset();
        mid();
        check("mreset_s_req", 64'(s_req), 0);
        step();
        set_req(3, 1'b0, 4'hF, 24'h40, 32'h0);
        mid();
        check("mreset_not_full", 64'(s_req), 1);
        step();
        clear_inputs();
        s_rvalid = 1'b1;
        mid();
        check("mreset_rvalid", 64'(m_rvalid), 0);
        step();
        s_rvalid = 1'b0;
        mid();
        check("mreset_err", 64'(err), 1);

        // Randomized traffic against the reference
        do_reset();
        rr = 0; lock = -1; q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NR; i++)
                if (!m_req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom), 4'($urandom), AW'($urandom), DW'($urandom));
            s_gnt    = ($urandom_range(0, 2) != 0);
            s_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;

            cand_found = 0;
            exp_cand   = 0;
            if (lock >= 0) begin
                exp_cand = lock; cand_found = 1;
            end else begin
                for (int k = 0; k < NR; k++)
                    if (!cand_found && m_req[(rr + k) % NR]) begin
                        exp_cand = (rr + k) % NR; cand_found = 1;
                    end
            end
            exp_sreq = (cand_found == 1) && (q.size() < MO);
            exp_gnt  = (exp_sreq && s_gnt) ? NR'(1 << exp_cand) : '0;
            exp_rv   = s_rvalid ? NR'(1 << q[0]) : '0;

            mid();
            check("rnd_s_req", 64'(s_req), 64'(exp_sreq));
            check("rnd_m_gnt", 64'(m_gnt), 64'(exp_gnt));
            check("rnd_m_rvalid", 64'(m_rvalid), 64'(exp_rv));
            check("rnd_m_rdata", 64'(m_rdata), 64'(s_rdata));
            if (exp_sreq) begin
                check("rnd_s_addr", 64'(s_addr), 64'(m_addr[exp_cand*AW +: AW]));
                check("rnd_s_wdata", 64'(s_wdata), 64'(m_wdata[exp_cand*DW +: DW]));
                check("rnd_s_we_be", {59'd0, s_we, s_be},
                      {59'd0, m_we[exp_cand], m_be[exp_cand*4 +: 4]});
            end
            step();

            if (s_rvalid) void'(q.pop_front());
            if (exp_sreq && s_gnt) begin
                q.push_back(exp_cand);
                rr   = (exp_cand + 1) % NR;
                lock = -1;
                m_req[exp_cand] = 1'b0;
            end else if (exp_sreq) begin
                lock = exp_cand;
            end else begin
                lock = -1;
            end
        end
        mid();
        check("rnd_no_err", 64'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
